// File: rtl/program_loader.sv
// Framed byte-stream loader that fills CPU instruction memory and holds the CPU in reset until a good frame.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module program_loader #(
  parameter int          DEPTH     = 10,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [11:0]       instr_in,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_OPC,
    S_OPR,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last;
  logic [3:0]        opc;
  logic              xfer;
  logic              is_sync;
  logic              bad_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer      = in_valid & in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign bad_count = (in_data == 8'd0) || (in_data > DEPTH[7:0]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d  = state;
    in_ready = 1'b1;
    we       = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (xfer && is_sync) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (xfer) state_d = bad_count ? S_ERR : S_OPC;
      end
      S_OPC: begin
        if (xfer) state_d = S_OPR;
      end
      S_OPR: begin
        if (xfer) state_d = S_WRITE;
      end
      S_WRITE: begin
        in_ready = 1'b0;
        we       = 1'b1;
        if (cnt == last) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_OPC;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (xfer && is_sync) state_d = S_COUNT;
      end
      S_ERR: begin
        err = 1'b1;
        if (xfer && is_sync) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot counter, field latches and the held write address/data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      last       <= '0;
      opc        <= '0;
      instr_addr <= '0;
      instr_in   <= '0;
    end else if (state == S_WRITE) begin
      cnt <= cnt + 1'b1;
    end else if (xfer) begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (is_sync) cnt <= '0;
        end
        S_COUNT: last <= ADDR_W'(in_data - 8'd1);
        S_OPC:   opc  <= in_data[7:4];
        S_OPR: begin
          instr_addr <= cnt;
          instr_in   <= {opc, in_data};
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of COUNT and every payload byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (xfer) begin
      unique case (state)
        S_COUNT:      csum <= in_data;
        S_OPC, S_OPR: csum <= csum ^ in_data;
        default: ;
      endcase
    end
  end
`endif

endmodule
